// File: rtl/branch_tracker_p_pkg.sv
// Shared types for the branch speculation tracker: compare kinds, operand,
// queue entry and RAS checkpoint layouts.
package branch_tracker_p_pkg;
  localparam int BT_TAG_W     = 4;
  localparam int BT_DATA_W    = 32;
  localparam int BT_ADDR_W    = 14;
  localparam int BT_RAS_DEPTH = 8;
  localparam int BT_SP_W      = $clog2(BT_RAS_DEPTH);

  typedef enum logic [1:0] {
    CMP_FZ  = 2'd0,
    CMP_FLE = 2'd1,
    CMP_EQ  = 2'd2,
    CMP_LE  = 2'd3
  } cmp_type_t;

  typedef struct packed {
    logic                 valid;
    logic [BT_TAG_W-1:0]  tag;
    logic [BT_DATA_W-1:0] data;
  } operand_t;

  typedef struct packed {
    logic [BT_SP_W-1:0]   sp;
    logic [BT_ADDR_W-1:0] slot;
  } ras_ckpt_t;

  typedef struct packed {
    cmp_type_t            cmp;
    operand_t             opd0;
    operand_t             opd1;
    logic                 pred;
    logic                 resolved;
    logic                 result;
    logic [BT_TAG_W-1:0]  gpr_tag;
    logic [BT_TAG_W-1:0]  fpr_tag;
    logic [BT_ADDR_W-1:0] fail_addr;
    ras_ckpt_t            ckpt;
  } entry_t;

  // Float compares take their operands from the FPR CDB, integer ones from the GPR CDB.
  function automatic logic uses_fpr(cmp_type_t c);
    return (c == CMP_FZ) || (c == CMP_FLE);
  endfunction
endpackage

// File: rtl/branch_tracker_p_fcmp_le.sv
// Combinational IEEE-754 single-precision a <= b; +0 and -0 compare equal,
// any NaN operand yields false.
module fcmp_le (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        le
);
  logic        a_nan, b_nan, both_zero;
  logic [30:0] a_mag, b_mag;

  assign a_mag     = a[30:0];
  assign b_mag     = b[30:0];
  assign a_nan     = (&a[30:23]) && (|a[22:0]);
  assign b_nan     = (&b[30:23]) && (|b[22:0]);
  assign both_zero = (a_mag == 31'd0) && (b_mag == 31'd0);

  always_comb begin
    le = 1'b0;
    if (a_nan || b_nan)      le = 1'b0;
    else if (both_zero)      le = 1'b1;
    else if (a[31] != b[31]) le = a[31];
    else if (!a[31])         le = (a_mag <= b_mag);
    else                     le = (a_mag >= b_mag);
  end
endmodule

// File: rtl/branch_tracker_p.sv
// In-order branch speculation tracker: snoops CDBs for compare operands,
// resolves one branch per cycle, retires at the ROB commit point and owns a checkpointed RAS.
module branch_tracker_p
  import branch_tracker_p_pkg::*;
#(
  parameter int N_ENTRY   = 4,
  parameter int RAS_DEPTH = BT_RAS_DEPTH,
  parameter int TAG_W     = BT_TAG_W,
  parameter int DATA_W    = BT_DATA_W,
  parameter int ADDR_W    = BT_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [1:0]                issue_cmp,
  input  logic [1:0]                issue_opd_valid,
  input  logic [2*TAG_W-1:0]        issue_opd_tag,
  input  logic [2*DATA_W-1:0]       issue_opd_data,
  input  logic                      issue_pred,
  input  logic [TAG_W-1:0]          issue_gpr_tag,
  input  logic [TAG_W-1:0]          issue_fpr_tag,
  input  logic [ADDR_W-1:0]         issue_fail_addr,
  input  logic                      gpr_cdb_valid,
  input  logic [TAG_W-1:0]          gpr_cdb_tag,
  input  logic [DATA_W-1:0]         gpr_cdb_data,
  input  logic                      fpr_cdb_valid,
  input  logic [TAG_W-1:0]          fpr_cdb_tag,
  input  logic [DATA_W-1:0]         fpr_cdb_data,
  input  logic [TAG_W-1:0]          gpr_commit_tag,
  input  logic [TAG_W-1:0]          fpr_commit_tag,
  output logic                      commit,
  output logic                      mispredict,
  output logic [ADDR_W-1:0]         fail_addr,
  output logic [$clog2(N_ENTRY):0]  count,
  input  logic                      ras_push,
  input  logic                      ras_pop,
  input  logic [ADDR_W-1:0]         ras_push_addr,
  output logic [ADDR_W-1:0]         ras_top
);
  localparam int CNT_W = $clog2(N_ENTRY) + 1;
  localparam int SP_W  = $clog2(RAS_DEPTH);

  entry_t            ent_q [N_ENTRY];
  entry_t            ent_d [N_ENTRY];
  entry_t            upd   [N_ENTRY];
  entry_t            new_ent;
  entry_t            res_ent;
  logic [CNT_W-1:0]  count_q, count_d, cnt_after;
  logic [N_ENTRY-1:0] res_go;
  logic              res_seen, res_val, fle_le, issue_fire;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] slot_q [RAS_DEPTH];
  logic [ADDR_W-1:0] slot_d [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_top_q, ras_top_d;

  function automatic operand_t snoop(operand_t o, logic use_fpr);
    operand_t r;
    r = o;
    if (!o.valid) begin
      if (use_fpr && fpr_cdb_valid && (fpr_cdb_tag == o.tag)) begin
        r.valid = 1'b1;
        r.data  = fpr_cdb_data;
      end else if (!use_fpr && gpr_cdb_valid && (gpr_cdb_tag == o.tag)) begin
        r.valid = 1'b1;
        r.data  = gpr_cdb_data;
      end
    end
    return r;
  endfunction

  function automatic logic opd_ready(entry_t e);
    return e.opd0.valid && ((e.cmp == CMP_FZ) || e.opd1.valid);
  endfunction

  function automatic logic eval_cmp(entry_t e, logic fle);
    case (e.cmp)
      CMP_FZ:  return (e.opd0.data[30:23] == 8'd0);
      CMP_FLE: return fle;
      CMP_EQ:  return (e.opd0.data == e.opd1.data);
      default: return ($signed(e.opd0.data) <= $signed(e.opd1.data));
    endcase
  endfunction

  assign commit      = (count_q != '0) && ent_q[0].resolved &&
                       (gpr_commit_tag == ent_q[0].gpr_tag) &&
                       (fpr_commit_tag == ent_q[0].fpr_tag);
  assign mispredict  = commit && (ent_q[0].result != ent_q[0].pred);
  assign fail_addr   = ent_q[0].fail_addr;
  assign count       = count_q;
  assign ras_top     = ras_top_q;
  assign issue_ready = !flush && ((count_q < CNT_W'(N_ENTRY)) || commit);
  assign issue_fire  = issue_valid && issue_ready;

  // Resolution strictly in order: only the oldest unresolved entry may compare.
  always_comb begin
    res_seen = 1'b0;
    res_go   = '0;
    res_ent  = ent_q[0];
    for (int i = 0; i < N_ENTRY; i++) begin
      if (!res_seen && (CNT_W'(i) < count_q) && !ent_q[i].resolved) begin
        res_seen = 1'b1;
        res_ent  = ent_q[i];
        res_go[i] = opd_ready(ent_q[i]);
      end
    end
  end

  fcmp_le u_fcmp_le (
    .a  (res_ent.opd0.data),
    .b  (res_ent.opd1.data),
    .le (fle_le)
  );

  assign res_val = eval_cmp(res_ent, fle_le);

  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      upd[i]      = ent_q[i];
      upd[i].opd0 = snoop(ent_q[i].opd0, uses_fpr(ent_q[i].cmp));
      upd[i].opd1 = snoop(ent_q[i].opd1, uses_fpr(ent_q[i].cmp));
      if (res_go[i]) begin
        upd[i].resolved = 1'b1;
        upd[i].result   = res_val;
      end
    end

    new_ent            = '0;
    new_ent.cmp        = cmp_type_t'(issue_cmp);
    new_ent.opd0.valid = issue_opd_valid[0];
    new_ent.opd0.tag   = issue_opd_tag[TAG_W-1:0];
    new_ent.opd0.data  = issue_opd_data[DATA_W-1:0];
    new_ent.opd1.valid = issue_opd_valid[1];
    new_ent.opd1.tag   = issue_opd_tag[2*TAG_W-1:TAG_W];
    new_ent.opd1.data  = issue_opd_data[2*DATA_W-1:DATA_W];
    new_ent.opd0       = snoop(new_ent.opd0, uses_fpr(new_ent.cmp));
    new_ent.opd1       = snoop(new_ent.opd1, uses_fpr(new_ent.cmp));
    new_ent.pred       = issue_pred;
    new_ent.gpr_tag    = issue_gpr_tag;
    new_ent.fpr_tag    = issue_fpr_tag;
    new_ent.fail_addr  = issue_fail_addr;
    new_ent.ckpt.sp    = sp_q;
    new_ent.ckpt.slot  = slot_q[sp_q];

    ent_d = upd;
    if (commit) begin
      for (int i = 0; i < N_ENTRY - 1; i++) ent_d[i] = upd[i+1];
    end
    cnt_after = count_q - CNT_W'(commit);
    if (issue_fire) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        if (CNT_W'(i) == cnt_after) ent_d[i] = new_ent;
      end
    end

    if (flush) count_d = '0;
    else       count_d = cnt_after + CNT_W'(issue_fire);
  end

  // RAS: a flush restores the head checkpoint and overrides any push/pop.
  always_comb begin
    sp_d   = sp_q;
    slot_d = slot_q;
    if (flush) begin
      if (count_q != '0) begin
        sp_d                      = ent_q[0].ckpt.sp;
        slot_d[ent_q[0].ckpt.sp]  = ent_q[0].ckpt.slot;
      end
    end else if (ras_push && ras_pop) begin
      slot_d[sp_q] = ras_push_addr;
    end else if (ras_push) begin
      sp_d         = sp_q + SP_W'(1);
      slot_d[sp_d] = ras_push_addr;
    end else if (ras_pop) begin
      sp_d = sp_q - SP_W'(1);
    end
    ras_top_d = slot_d[sp_d];
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      sp_q      <= SP_W'(RAS_DEPTH - 1);
      ras_top_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) slot_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      sp_q      <= sp_d;
      ras_top_q <= ras_top_d;
      slot_q    <= slot_d;
    end
  end
endmodule

// File: tb/tb_branch_tracker_p.sv
// Directed bench for branch_tracker_p: resolve/commit, CDB snoop, full queue,
// RAS checkpoint restore, RAS wrap and reset-over-flush.
module tb_branch_tracker_p;
  localparam int TAG_W = 4, DATA_W = 32, ADDR_W = 14;

  logic clk, reset, flush, issue_valid, issue_ready, issue_pred;
  logic [1:0] issue_cmp, issue_opd_valid;
  logic [2*TAG_W-1:0] issue_opd_tag;
  logic [2*DATA_W-1:0] issue_opd_data;
  logic [TAG_W-1:0] issue_gpr_tag, issue_fpr_tag, gpr_cdb_tag, fpr_cdb_tag;
  logic [TAG_W-1:0] gpr_commit_tag, fpr_commit_tag;
  logic [ADDR_W-1:0] issue_fail_addr, fail_addr, ras_push_addr, ras_top;
  logic gpr_cdb_valid, fpr_cdb_valid, commit, mispredict, ras_push, ras_pop;
  logic [DATA_W-1:0] gpr_cdb_data, fpr_cdb_data;
  logic [2:0] count;
  int total = 0, bad = 0;

  branch_tracker_p dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_cmp(issue_cmp),
    .issue_opd_valid(issue_opd_valid), .issue_opd_tag(issue_opd_tag),
    .issue_opd_data(issue_opd_data), .issue_pred(issue_pred),
    .issue_gpr_tag(issue_gpr_tag), .issue_fpr_tag(issue_fpr_tag),
    .issue_fail_addr(issue_fail_addr),
    .gpr_cdb_valid(gpr_cdb_valid), .gpr_cdb_tag(gpr_cdb_tag), .gpr_cdb_data(gpr_cdb_data),
    .fpr_cdb_valid(fpr_cdb_valid), .fpr_cdb_tag(fpr_cdb_tag), .fpr_cdb_data(fpr_cdb_data),
    .gpr_commit_tag(gpr_commit_tag), .fpr_commit_tag(fpr_commit_tag),
    .commit(commit), .mispredict(mispredict), .fail_addr(fail_addr), .count(count),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_push_addr(ras_push_addr), .ras_top(ras_top)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_cmp = 0; issue_opd_valid = 0;
    issue_opd_tag = 0; issue_opd_data = 0; issue_pred = 0;
    issue_gpr_tag = 0; issue_fpr_tag = 0; issue_fail_addr = 0;
    gpr_cdb_valid = 0; gpr_cdb_tag = 0; gpr_cdb_data = 0;
    fpr_cdb_valid = 0; fpr_cdb_tag = 0; fpr_cdb_data = 0;
    ras_push = 0; ras_pop = 0; ras_push_addr = 0;
  endtask

  task automatic drive_issue(input logic [1:0] cmp, input logic [1:0] vld,
                             input logic [3:0] t0, input logic [3:0] t1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic pred, input logic [3:0] gt, input logic [3:0] ft,
                             input logic [13:0] fa);
    issue_valid = 1; issue_cmp = cmp; issue_opd_valid = vld;
    issue_opd_tag = {t1, t0}; issue_opd_data = {d1, d0}; issue_pred = pred;
    issue_gpr_tag = gt; issue_fpr_tag = ft; issue_fail_addr = fa;
  endtask

  // One branch with both operands ready: issue, resolve, then commit.
  task automatic run_single(input string tag, input logic [1:0] cmp,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic pred, input logic exp_mis);
    drive_issue(cmp, 2'b11, 4'h0, 4'h0, d0, d1, pred, 4'h3, 4'h4, 14'h033);
    tick(); idle(); tick();
    gpr_commit_tag = 4'h3; fpr_commit_tag = 4'h4;
    #1;
    chk({tag, "_commit"}, commit, 1);
    chk({tag, "_mis"}, mispredict, exp_mis);
    tick();
    gpr_commit_tag = 4'hF; fpr_commit_tag = 4'hF;
    chk({tag, "_cnt"}, count, 0);
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  initial begin
    idle();
    gpr_commit_tag = 4'hF; fpr_commit_tag = 4'hF;
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_commit", commit, 0);
    chk("rst_mis", mispredict, 0);
    chk("rst_top", ras_top, 0);
    chk("rst_ready", issue_ready, 1);

    // EQ 5 vs 5 predicted taken, commit two cycles after issue
    drive_issue(2'd2, 2'b11, 4'h0, 4'h0, 32'd5, 32'd5, 1'b1, 4'h2, 4'h1, 14'h0AA);
    chk("eq_ready", issue_ready, 1);
    tick(); idle();
    chk("eq_cnt1", count, 1);
    chk("eq_nocommit", commit, 0);
    tick();
    gpr_commit_tag = 4'h2; fpr_commit_tag = 4'h1;
    #1;
    chk("eq_commit", commit, 1);
    chk("eq_mis", mispredict, 0);
    chk("eq_faddr", fail_addr, 14'h0AA);
    tick();
    chk("eq_cnt0", count, 0);
    gpr_commit_tag = 4'hF; fpr_commit_tag = 4'hF;

    // LE with opd0 from GPR CDB: -2 <= -1 taken, predicted not taken
    drive_issue(2'd3, 2'b10, 4'h3, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 4'h5, 4'h6, 14'h1ABC);
    tick(); idle();
    gpr_cdb_valid = 1; gpr_cdb_tag = 4'h3; gpr_cdb_data = 32'hFFFF_FFFE;
    gpr_commit_tag = 4'h5; fpr_commit_tag = 4'h6;
    #1;
    chk("le_wait1", commit, 0);
    tick(); gpr_cdb_valid = 0;
    chk("le_wait2", commit, 0);
    tick();
    chk("le_commit", commit, 1);
    chk("le_mis", mispredict, 1);
    chk("le_faddr", fail_addr, 14'h1ABC);
    tick();
    chk("le_cnt0", count, 0);
    gpr_commit_tag = 4'hF; fpr_commit_tag = 4'hF;

    // FZ with same-cycle FPR bypass; GPR CDB carries a decoy on the same tag
    drive_issue(2'd0, 2'b00, 4'h7, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 4'h1, 4'h2, 14'h022);
    fpr_cdb_valid = 1; fpr_cdb_tag = 4'h7; fpr_cdb_data = 32'h0000_0001;
    gpr_cdb_valid = 1; gpr_cdb_tag = 4'h7; gpr_cdb_data = 32'h3F80_0000;
    tick(); idle(); tick();
    gpr_commit_tag = 4'h1; fpr_commit_tag = 4'h2;
    #1;
    chk("fz_commit", commit, 1);
    chk("fz_mis", mispredict, 0);
    tick();
    gpr_commit_tag = 4'hF; fpr_commit_tag = 4'hF;

    run_single("fle_zero", 2'd1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1);
    run_single("fle_gt",   2'd1, 32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b0);
    run_single("fle_neg",  2'd1, 32'hC000_0000, 32'hBF80_0000, 1'b1, 1'b0);
    run_single("eq_ne",    2'd2, 32'd5, 32'd6, 1'b1, 1'b1);
    run_single("le_sgn",   2'd3, 32'd3, 32'hFFFF_FFFC, 1'b1, 1'b1);
    run_single("fz_nz",    2'd0, 32'h3F80_0000, 32'h0, 1'b0, 1'b0);

    // Fill the queue, then offer a fifth branch
    for (int i = 0; i < 4; i++) begin
      drive_issue(2'd2, 2'b11, 4'h0, 4'h0, 32'd1, 32'd1, 1'b1, 4'(i), 4'h0, 14'(i));
      tick();
    end
    drive_issue(2'd2, 2'b11, 4'h0, 4'h0, 32'd1, 32'd1, 1'b1, 4'h4, 4'h0, 14'h4);
    chk("full_cnt", count, 4);
    chk("full_ready0", issue_ready, 0);
    gpr_commit_tag = 4'h0; fpr_commit_tag = 4'h0;
    #1;
    chk("full_ready1", issue_ready, 1);
    chk("full_commit", commit, 1);
    tick(); idle();
    gpr_commit_tag = 4'hF; fpr_commit_tag = 4'hF;
    chk("full_cnt_kept", count, 4);
    chk("full_head", fail_addr, 14'h1);
    flush = 1;
    #1;
    chk("flush_ready", issue_ready, 0);
    tick(); flush = 0;
    chk("flush_cnt", count, 0);

    // RAS checkpoint: push, issue, pop, push, flush restores
    ras_push = 1; ras_push_addr = 14'h100;
    tick(); ras_push = 0;
    chk("ras_push1", ras_top, 14'h100);
    drive_issue(2'd2, 2'b11, 4'h0, 4'h0, 32'd1, 32'd1, 1'b1, 4'hE, 4'hE, 14'h0);
    tick(); idle();
    ras_pop = 1;
    tick(); ras_pop = 0;
    chk("ras_pop", ras_top, 14'h0);
    ras_push = 1; ras_push_addr = 14'h200;
    tick(); ras_push = 0;
    chk("ras_push2", ras_top, 14'h200);
    flush = 1;
    tick();
    chk("ras_restore", ras_top, 14'h100);
    chk("ras_flush_cnt", count, 0);
    ras_push = 1; ras_push_addr = 14'h300;
    tick(); idle();
    chk("ras_flush_empty", ras_top, 14'h100);

    // RAS wrap: nine pushes into eight slots
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      ras_push = 1; ras_push_addr = 14'(k);
      tick();
    end
    ras_push = 0;
    ras_pop = 1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wrap_%0d", k), ras_top, 32'(9 - k));
      tick();
    end
    ras_pop = 0;
    chk("wrap_end", ras_top, 14'h9);
    ras_push = 1; ras_pop = 1; ras_push_addr = 14'h55;
    tick();
    chk("pushpop", ras_top, 14'h55);
    ras_push = 0;
    tick(); ras_pop = 0;
    chk("pushpop_pop", ras_top, 14'h8);

    // Reset wins over flush mid-queue
    drive_issue(2'd2, 2'b11, 4'h0, 4'h0, 32'd1, 32'd2, 1'b0, 4'hE, 4'hE, 14'h7);
    tick(); tick(); idle();
    chk("mid_cnt", count, 2);
    reset = 1; flush = 1; ras_push = 1; ras_push_addr = 14'h77;
    tick();
    reset = 0; idle();
    chk("rstfl_cnt", count, 0);
    chk("rstfl_sp", dut.sp_q, 7);
    chk("rstfl_top", ras_top, 0);
    chk("rstfl_commit", commit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_tracker_p.md
Name: branch_tracker_p

Overview:
- Parametrised, in-order branch speculation tracker for the out-of-order core.
- Holds up to N_ENTRY unresolved or uncommitted conditional branches. Captures their compare operands from the GPR/FPR CDBs and resolves one compare per cycle.
- Commits the oldest branch once both ROB commit pointers reach its issue-time tags, and flags mispredictions.
- Owns a return-address stack (RAS) that is checkpointed per branch and restored on flush.

Parameters:
- N_ENTRY, 4, branch queue depth (>=2).
- RAS_DEPTH, 8, return-address stack depth (power of two).
- TAG_W, 4, ROB tag width.
- DATA_W, 32, operand width.
- ADDR_W, 14, instruction address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  squash all speculation (asserted by core after committed mispredict)
- issue_valid  in  1  new branch offered
- issue_ready  out  1  = !flush && (count<N_ENTRY || commit)
- issue_cmp  in  2  0 FZ (opd0 exponent==0), 1 FLE, 2 EQ, 3 signed LE
- issue_opd_valid  in  2  per-operand ready
- issue_opd_tag  in  2*TAG_W  producer tags
- issue_opd_data  in  2*DATA_W  values (immediate already substituted)
- issue_pred  in  1  predicted taken
- issue_gpr_tag, issue_fpr_tag  in  TAG_W each  ROB issue pointers at issue
- issue_fail_addr  in  ADDR_W  redirect target if mispredicted
- gpr_cdb_valid/tag/data  in  1/TAG_W/DATA_W  integer CDB
- fpr_cdb_valid/tag/data  in  1/TAG_W/DATA_W  float CDB
- gpr_commit_tag, fpr_commit_tag  in  TAG_W each  ROB commit pointers
- commit  out  1  head branch retires this cycle
- mispredict  out  1  commit && head result != head pred
- fail_addr  out  ADDR_W  head's redirect address
- count  out  $clog2(N_ENTRY)+1  occupied entries
- ras_push, ras_pop  in  1 each  call / return
- ras_push_addr  in  ADDR_W  return address pushed
- ras_top  out  ADDR_W  registered top-of-stack

Behaviour:
- Reset: count=0, sp=RAS_DEPTH-1, all RAS slots=0, ras_top=0. commit and mispredict are therefore 0.
- Allocation: on issue_valid&&issue_ready, append at tail. Store cmp, operands, pred, ROB tags, fail_addr, and a RAS checkpoint {sp, slot[sp]} taken before this cycle's push/pop.
- CDB snoop:
  - EQ/LE operands watch the GPR CDB; FZ/FLE operands watch the FPR CDB.
  - A matching valid tag sets the operand valid and captures data.
  - Snooping also applies to operands arriving in the issue cycle (same-cycle bypass).
- Resolve:
  - Each cycle, the oldest unresolved entry whose needed operands are valid (FZ needs opd0 only) is compared.
  - The result and resolved flag are written at the next edge.
  - Resolution is strictly in order; a younger ready entry waits behind an older unready one.
  - FLE uses the fcmp_le sub-module.
- Commit:
  - commit is combinational = count!=0 && head resolved && gpr_commit_tag==head.gpr_tag && fpr_commit_tag==head.fpr_tag.
  - Head pops at the edge.
  - A resolve landing on the head in the same cycle is not visible to commit until the next cycle.
- count_next = count - commit + issue. Issue and commit in the same cycle are legal when full.
- Flush:
  - At the edge, count=0 and all entries are dropped.
  - sp is restored to head checkpoint sp, and slot[sp] is restored to the checkpointed value.
  - This restore overrides ras_push/ras_pop in that cycle.
  - If count==0, RAS state is unchanged.
  - Recovery covers at most one pop-then-push overwrite per branch; deeper corruption is accepted.
- RAS update:
  - push: sp+1 (mod RAS_DEPTH), slot=addr; on overflow the oldest entry is silently overwritten.
  - pop: sp-1 (mod RAS_DEPTH).
  - push&&pop: sp unchanged, slot[sp]=addr.
- ras_top is registered as the next-state slot[sp_next], so it is valid in the cycle after any update.
- Priority: reset > flush > normal operation.

Decomposition:
- Shared package holds:
  - cmp_type_t enum (FZ, FLE, EQ, LE).
  - Operand struct {valid, tag, data}.
  - Branch entry struct and RAS checkpoint struct.
- Sub-module fcmp_le: combinational IEEE-754 single-precision a<=b, with ±0 equal.
- Queue storage is either a shift register or a circular buffer; it must be unobservable at the ports.

Test Plan:
- Issue EQ with opd 5 vs 5 both valid and pred=1; gpr/fpr commit tags match two cycles later -> commit=1, mispredict=0, count 1->0.
- Issue LE with opd0 tag 3 invalid and opd1 = -1; GPR CDB tag 3 data 0xFFFFFFFE one cycle later -> resolves taken; with pred=0 -> mispredict=1, fail_addr=issue value.
- Fill N_ENTRY=4, then offer a 5th with the head committable -> issue_ready=1, count stays 4; with head not committable -> issue_ready=0.
- Push 0x100, issue branch, pop, push 0x200, flush -> ras_top=0x100 next cycle, count=0.
- Push 9 times with RAS_DEPTH=8 -> wrap; 8 pops return pushes 9..2 in order.
- Assert reset mid-queue with flush=1 -> count=0, sp=7, ras_top=0 next cycle.
